// File: rtl/pll_reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_reset_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   - state_t   : sequencer state encoding
//   - cnt_width : width of the shared phase counter, sized for the largest
//                 terminal count plus one bit of headroom
// -----------------------------------------------------------------------------
package pll_reset_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      FILTER    = 3'd1,
      HOLD      = 3'd2,
      STAGGER   = 3'd3,
      RUN       = 3'd4
   } state_t;

   // Width of the shared counter: clog2 of the largest terminal count, plus 1.
   function automatic int cnt_width(input int lock_filter,
                                    input int hold_cycles,
                                    input int stage_gap);
      int m;
      m = lock_filter;
      if (hold_cycles > m) begin
         m = hold_cycles;
      end
      if (stage_gap > m) begin
         m = stage_gap;
      end
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pll_reset_seq_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Level debouncer for the already-synchronized reset button. The output only
// follows the input after the input has held its new level for
// DEBOUNCE_CYCLES consecutive clock cycles; shorter pulses are dropped.
// Only instantiated when RST_BTN_DEBOUNCE_EN is defined.
//
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-high reset (output and counter cleared)
//   i_btn   : synchronized button level
//   o_btn   : debounced button level (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_btn
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DW-1:0] DB_TERM = DW'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0] r_cnt;
   logic          r_btn;

   // Count consecutive cycles the input differs from the output; flip when full.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
         r_btn <= 1'b0;
      end else if (i_btn != r_btn) begin
         if (r_cnt == DB_TERM) begin
            r_btn <= i_btn;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DW'(1);
         end
      end else begin
         // Any return to the current output level restarts the stability window.
         r_cnt <= '0;
      end
   end

   assign o_btn = r_btn;

endmodule

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
// Reset sequencer downstream of the system PLL. Waits for a filtered PLL lock,
// holds both resets for HOLD_CYCLES, releases the peripheral reset, then after
// STAGE_GAP cycles releases the CPU reset and raises ready. Loss of lock
// restarts from WAIT_LOCK; a button press restarts from HOLD.
//
// Optional feature: define RST_BTN_DEBOUNCE_EN to route the synchronized
// button through btn_debounce (DEBOUNCE_CYCLES stable cycles per change).
//
// Ports:
//   i_clk        : PLL output clock
//   i_reset      : synchronous active-high block reset
//   i_locked     : PLL lock flag, asynchronous
//   i_btn_reset  : board reset button, active-high, asynchronous
//   o_rst_periph : active-high reset for SDRAM/video, released first
//   o_rst_cpu    : active-high reset for the CPU core, released last
//   o_ready      : high once both resets are released
// -----------------------------------------------------------------------------
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int LOCK_FILTER     = 1024,
   parameter int HOLD_CYCLES     = 65536,
   parameter int STAGE_GAP       = 16,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_locked,
   input  logic i_btn_reset,
   output logic o_rst_periph,
   output logic o_rst_cpu,
   output logic o_ready
);

   localparam int CW = cnt_width(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);
   localparam logic [CW-1:0] LF_TERM = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] HC_TERM = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] SG_TERM = CW'(STAGE_GAP - 1);

   // Elaboration-time parameter sanity check.
   if (LOCK_FILTER < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("pll_reset_seq: all cycle parameters must be >= 1");
   end

   logic          r_lock_meta;
   logic          r_lock_sync;
   logic          r_btn_meta;
   logic          r_btn_sync;
   logic          w_btn_s;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_rst_periph;
   logic          r_rst_cpu;
   logic          r_ready;
   logic          w_rst_periph_nxt;
   logic          w_rst_cpu_nxt;

   // Two-flop synchronizers for the asynchronous lock and button inputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
         r_btn_meta  <= 1'b0;
         r_btn_sync  <= 1'b0;
      end else begin
         r_lock_meta <= i_locked;
         r_lock_sync <= r_lock_meta;
         r_btn_meta  <= i_btn_reset;
         r_btn_sync  <= r_btn_meta;
      end
   end

`ifdef RST_BTN_DEBOUNCE_EN
   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn   (r_btn_sync),
      .o_btn   (w_btn_s)
   );
`else
   assign w_btn_s = r_btn_sync;
`endif

   // State, counter and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= WAIT_LOCK;
         r_cnt        <= '0;
         r_rst_periph <= 1'b1;
         r_rst_cpu    <= 1'b1;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_rst_periph <= w_rst_periph_nxt;
         r_rst_cpu    <= w_rst_cpu_nxt;
         r_ready      <= ~w_rst_cpu_nxt;
      end
   end

   // Next state and counter; lock loss beats the button, which beats counting.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!r_lock_sync) begin
         w_state_nxt = WAIT_LOCK;
         w_cnt_nxt   = '0;
      end else if (w_btn_s) begin
         // Button held: park in HOLD with the counter pinned at zero.
         w_state_nxt = HOLD;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               w_state_nxt = FILTER;
               w_cnt_nxt   = '0;
            end
            FILTER: begin
               if (r_cnt == LF_TERM) begin
                  w_state_nxt = HOLD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            HOLD: begin
               if (r_cnt == HC_TERM) begin
                  w_state_nxt = STAGGER;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            STAGGER: begin
               if (r_cnt == SG_TERM) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            RUN: begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end
            default: begin
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Output values for the state being entered; registered above so that
   // outputs are a pure function of flops.
   always_comb begin
      w_rst_periph_nxt = 1'b1;
      w_rst_cpu_nxt    = 1'b1;
      case (w_state_nxt)
         STAGGER: begin
            w_rst_periph_nxt = 1'b0;
            w_rst_cpu_nxt    = 1'b1;
         end
         RUN: begin
            w_rst_periph_nxt = 1'b0;
            w_rst_cpu_nxt    = 1'b0;
         end
         default: begin
            w_rst_periph_nxt = 1'b1;
            w_rst_cpu_nxt    = 1'b1;
         end
      endcase
   end

   assign o_rst_periph = r_rst_periph;
   assign o_rst_cpu    = r_rst_cpu;
   assign o_ready      = r_ready;

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
// Directed self-checking bench for pll_reset_seq with LOCK_FILTER=8,
// HOLD_CYCLES=16, STAGE_GAP=4, DEBOUNCE_CYCLES=8. Inputs change on the falling
// edge, so "edge e" is the next rising edge; outputs are sampled on the
// falling edge after it. Button scenarios follow RST_BTN_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

   logic clk;
   logic reset;
   logic locked;
   logic btn_reset;
   logic o_rst_periph;
   logic o_rst_cpu;
   logic o_ready;

   int checks;
   int failures;

   pll_reset_seq #(
      .LOCK_FILTER     (8),
      .HOLD_CYCLES     (16),
      .STAGE_GAP       (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_locked     (locked),
      .i_btn_reset  (btn_reset),
      .o_rst_periph (o_rst_periph),
      .o_rst_cpu    (o_rst_cpu),
      .o_ready      (o_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then land on the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_and_clean_lock();
      logic ep, ec, er;
      reset     = 1'b1;
      locked    = 1'b1;
      btn_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b110) begin
            failures++;
            $display("FAIL reset_values cyc=%0d got=%b%b%b exp=110", i, o_rst_periph, o_rst_cpu, o_ready);
         end
      end
      reset = 1'b0;
      for (int e = 0; e <= 34; e++) begin
         tick();
         ep = (e < 26);
         ec = (e < 30);
         er = (e >= 30);
         checks++;
         if (o_rst_periph !== ep) begin
            failures++;
            $display("FAIL clean_periph edge=%0d got=%b exp=%b", e, o_rst_periph, ep);
         end
         checks++;
         if (o_rst_cpu !== ec) begin
            failures++;
            $display("FAIL clean_cpu edge=%0d got=%b exp=%b", e, o_rst_cpu, ec);
         end
         checks++;
         if (o_ready !== er) begin
            failures++;
            $display("FAIL clean_ready edge=%0d got=%b exp=%b", e, o_ready, er);
         end
      end
   endtask

   task automatic test_lock_glitch();
      logic ep, ec;
      locked = 1'b0;
      repeat (6) tick();
      for (int e = 0; e <= 54; e++) begin
         locked = (e < 5) || (e >= 20);
         tick();
         ep = (e < 46);
         ec = (e < 50);
         checks++;
         if (o_rst_periph !== ep) begin
            failures++;
            $display("FAIL glitch_periph edge=%0d got=%b exp=%b", e, o_rst_periph, ep);
         end
         checks++;
         if (o_ready !== ~ec) begin
            failures++;
            $display("FAIL glitch_ready edge=%0d got=%b exp=%b", e, o_ready, ~ec);
         end
      end
   endtask

   task automatic test_lock_loss();
      logic ep, er;
      for (int e = 0; e <= 5; e++) begin
         locked = 1'b0;
         tick();
         if (e == 1) begin
            checks++;
            if (o_ready !== 1'b1) begin
               failures++;
               $display("FAIL loss_still_ready edge=%0d got=%b exp=1", e, o_ready);
            end
         end
         if (e >= 3) begin
            checks++;
            if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b110) begin
               failures++;
               $display("FAIL loss_resets edge=%0d got=%b%b%b exp=110", e, o_rst_periph, o_rst_cpu, o_ready);
            end
         end
      end
      for (int e = 0; e <= 34; e++) begin
         locked = 1'b1;
         tick();
         ep = (e < 26);
         er = (e >= 30);
         checks++;
         if (o_rst_periph !== ep) begin
            failures++;
            $display("FAIL relock_periph edge=%0d got=%b exp=%b", e, o_rst_periph, ep);
         end
         checks++;
         if (o_ready !== er || o_rst_cpu !== ~er) begin
            failures++;
            $display("FAIL relock_cpu edge=%0d got cpu=%b ready=%b exp ready=%b", e, o_rst_cpu, o_ready, er);
         end
      end
   endtask

`ifndef RST_BTN_DEBOUNCE_EN
   // Press for len edges starting at edge 0; rel is the edge after which
   // rst_periph must be low again (len + 17).
   task automatic test_button(input int len, input int rel);
      for (int e = 0; e <= rel + 6; e++) begin
         btn_reset = (e < len);
         tick();
         if (e == 1) begin
            checks++;
            if (o_ready !== 1'b1) begin
               failures++;
               $display("FAIL btn%0d_early edge=%0d ready got=%b exp=1", len, e, o_ready);
            end
         end
         if (e == 3 || e == rel - 1) begin
            checks++;
            if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b110) begin
               failures++;
               $display("FAIL btn%0d_held edge=%0d got=%b%b%b exp=110", len, e, o_rst_periph, o_rst_cpu, o_ready);
            end
         end
         if (e == rel) begin
            checks++;
            if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b010) begin
               failures++;
               $display("FAIL btn%0d_periph_rel edge=%0d got=%b%b%b exp=010", len, e, o_rst_periph, o_rst_cpu, o_ready);
            end
         end
         if (e == rel + 3 || e == rel + 4) begin
            checks++;
            if (o_ready !== (e == rel + 4)) begin
               failures++;
               $display("FAIL btn%0d_cpu_rel edge=%0d ready got=%b", len, e, o_ready);
            end
         end
      end
   endtask
`else
   task automatic test_debounce();
      for (int e = 0; e <= 24; e++) begin
         btn_reset = (e < 5);
         tick();
         checks++;
         if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL db_short edge=%0d ready got=%b exp=1", e, o_ready);
         end
      end
      for (int e = 0; e <= 45; e++) begin
         btn_reset = (e < 12);
         tick();
         if (e == 9) begin
            checks++;
            if (o_ready !== 1'b1) begin
               failures++;
               $display("FAIL db_latency edge=%0d ready got=%b exp=1", e, o_ready);
            end
         end
         if (e == 12 || e == 36) begin
            checks++;
            if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b110) begin
               failures++;
               $display("FAIL db_held edge=%0d got=%b%b%b exp=110", e, o_rst_periph, o_rst_cpu, o_ready);
            end
         end
         if (e == 37) begin
            checks++;
            if (o_rst_periph !== 1'b0) begin
               failures++;
               $display("FAIL db_periph_rel edge=%0d got=%b exp=0", e, o_rst_periph);
            end
         end
         if (e == 41) begin
            checks++;
            if (o_ready !== 1'b1) begin
               failures++;
               $display("FAIL db_ready edge=%0d got=%b exp=1", e, o_ready);
            end
         end
      end
   endtask
`endif

   task automatic test_mid_reset();
      logic ep, er;
      locked = 1'b0;
      repeat (6) tick();
      for (int e = 0; e <= 27; e++) begin
         locked = 1'b1;
         reset  = (e == 27);
         tick();
         if (e == 26) begin
            checks++;
            if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b010) begin
               failures++;
               $display("FAIL mid_stagger edge=%0d got=%b%b%b exp=010", e, o_rst_periph, o_rst_cpu, o_ready);
            end
         end
         if (e == 27) begin
            checks++;
            if ({o_rst_periph, o_rst_cpu, o_ready} !== 3'b110) begin
               failures++;
               $display("FAIL mid_reset edge=%0d got=%b%b%b exp=110", e, o_rst_periph, o_rst_cpu, o_ready);
            end
         end
      end
      reset = 1'b0;
      for (int e = 0; e <= 34; e++) begin
         tick();
         ep = (e < 26);
         er = (e >= 30);
         checks++;
         if (o_rst_periph !== ep) begin
            failures++;
            $display("FAIL restart_periph edge=%0d got=%b exp=%b", e, o_rst_periph, ep);
         end
         checks++;
         if (o_ready !== er || o_rst_cpu !== ~er) begin
            failures++;
            $display("FAIL restart_cpu edge=%0d got cpu=%b ready=%b exp ready=%b", e, o_rst_cpu, o_ready, er);
         end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      locked    = 1'b0;
      btn_reset = 1'b0;
      @(negedge clk);
      test_reset_and_clean_lock();
      test_lock_glitch();
      test_lock_loss();
`ifndef RST_BTN_DEBOUNCE_EN
      test_button(1, 18);
      test_button(4, 21);
`else
      test_debounce();
`endif
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
